// File: rtl/vga_timing_gen.sv
// VGA raster timing: 10-bit pixel/line counters, registered zero-skew decodes and per-frame event pulses.
// Defining VGA_SYNC_DELAY_EN adds a SYNC_DELAY-stage pin-side pipeline on hsync/vsync/blank_n.
module vga_timing_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   SYNC_DELAY  = 2
) (
    input  logic       pix_clk,
    input  logic       reset,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       bright,
    output logic       frame_start,
    output logic       vblank_start,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Window bounds are 11 bits so an end bound equal to 1024 cannot wrap to 0.
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

`ifdef VGA_SYNC_DELAY_EN
    localparam int PIPE_DEPTH = SYNC_DELAY;
`else
    localparam int PIPE_DEPTH = 0 * SYNC_DELAY;
`endif

    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        bright_next;
    logic        hsync_next;
    logic        vsync_next;
    logic        frame_next;
    logic        vblank_next;
    logic        hsync_raw;
    logic        vsync_raw;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        h_next = hcount + 10'd1;
        v_next = vcount;
        if (hcount == H_LAST) begin
            h_next = '0;
            v_next = (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end
    end

    // Decodes look at the next counter value so the registered outputs line up with the counters.
    assign h_ext       = {1'b0, h_next};
    assign v_ext       = {1'b0, v_next};
    assign bright_next = (h_ext < H_VIS) && (v_ext < V_VIS);
    assign hsync_next  = (h_ext >= HS_START && h_ext < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync_next  = (v_ext >= VS_START && v_ext < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign frame_next  = (h_next == '0) && (v_next == '0);
    assign vblank_next = (h_next == '0) && (v_ext == V_VIS);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            hcount       <= '0;
            vcount       <= '0;
            bright       <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            hsync_raw    <= ~SYNC_ACTIVE;
            vsync_raw    <= ~SYNC_ACTIVE;
        end else begin
            hcount       <= h_next;
            vcount       <= v_next;
            bright       <= bright_next;
            frame_start  <= frame_next;
            vblank_start <= vblank_next;
            hsync_raw    <= hsync_next;
            vsync_raw    <= vsync_next;
        end
    end

    generate
        if (PIPE_DEPTH > 0) begin : g_pipe
            logic [PIPE_DEPTH-1:0] hs_pipe;
            logic [PIPE_DEPTH-1:0] vs_pipe;
            logic [PIPE_DEPTH-1:0] bn_pipe;

            // NOTE: the stages are reset so a sync pulse in flight cannot leak out after reset.
            always_ff @(posedge pix_clk) begin
                if (reset) begin
                    hs_pipe <= {PIPE_DEPTH{~SYNC_ACTIVE}};
                    vs_pipe <= {PIPE_DEPTH{~SYNC_ACTIVE}};
                    bn_pipe <= '0;
                end else begin
                    hs_pipe[0] <= hsync_raw;
                    vs_pipe[0] <= vsync_raw;
                    bn_pipe[0] <= bright;
                    for (int i = 1; i < PIPE_DEPTH; i++) begin
                        hs_pipe[i] <= hs_pipe[i-1];
                        vs_pipe[i] <= vs_pipe[i-1];
                        bn_pipe[i] <= bn_pipe[i-1];
                    end
                end
            end

            assign hsync   = hs_pipe[PIPE_DEPTH-1];
            assign vsync   = vs_pipe[PIPE_DEPTH-1];
            assign blank_n = bn_pipe[PIPE_DEPTH-1];
        end else begin : g_direct
            assign hsync   = hsync_raw;
            assign vsync   = vsync_raw;
            assign blank_n = bright;
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (32x19) so several whole frames fit in a short run.
// The reference model tracks one linear frame position and derives every output from it arithmetically.
module tb_vga_timing_gen;

    localparam int   HV = 16, HF = 4, HS = 6, HB = 6;
    localparam int   VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int   HT = HV + HF + HS + HB;
    localparam int   VT = VV + VF + VS + VB;
    localparam int   FRAME = HT * VT;
    localparam logic SA = 1'b0;
    localparam int   SD = 2;
`ifdef VGA_SYNC_DELAY_EN
    localparam int   D = SD;
`else
    localparam int   D = 0;
`endif

    logic       pix_clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       bright;
    logic       frame_start;
    logic       vblank_start;
    logic       hsync;
    logic       vsync;
    logic       blank_n;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(SA), .SYNC_DELAY(SD)
    ) dut (
        .pix_clk(pix_clk),
        .reset(reset),
        .hcount(hcount),
        .vcount(vcount),
        .bright(bright),
        .frame_start(frame_start),
        .vblank_start(vblank_start),
        .hsync(hsync),
        .vsync(vsync),
        .blank_n(blank_n)
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       br;
        logic       fs;
        logic       vb;
        logic       hs;
        logic       vs;
        logic       bn;
    } obs_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic bn;
    } pin_t;

    obs_t exp_q[$];
    pin_t pin_hist[$];
    int   pos = 0;
    int   checks = 0;
    int   passed = 0;

    // Statistics gathered by the monitor since the most recent reset edge.
    logic rst_seen = 1'b1;
    int   cyc = 0;
    int   since_rel = 0;
    int   fs_first = -1;
    int   fs_last = -1;
    int   fs_gap = -1;
    int   fs_seen = 0;
    int   vb_first = -1;
    int   vb_seen = 0;
    int   vs_frame2 = 0;
    int   both_cnt = 0;

    task automatic check(input string name, input bit ok, input string act, input string exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %s, expected %s", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        check(name, act == exp, $sformatf("%0d", act), $sformatf("%0d", exp));
    endtask

    function automatic string fmt(input obs_t o);
        return $sformatf("h=%0d v=%0d bright=%b fs=%b vb=%b hsync=%b vsync=%b blank_n=%b",
                         o.h, o.v, o.br, o.fs, o.vb, o.hs, o.vs, o.bn);
    endfunction

    // Predict what the DUT shows after the next clock edge, given the reset level at that edge.
    task automatic model_step(input bit r);
        obs_t e;
        pin_t raw;
        pin_t idle;
        int   h;
        int   v;
        e = '0;
        idle.hs = ~SA;
        idle.vs = ~SA;
        idle.bn = 1'b0;
        if (r) begin
            pos = 0;
            pin_hist.delete();
            for (int i = 0; i <= D; i++) pin_hist.push_back(idle);
        end else begin
            pos = (pos + 1) % FRAME;
            h = pos % HT;
            v = pos / HT;
            e.h  = 10'(h);
            e.v  = 10'(v);
            e.br = (h < HV) && (v < VV);
            e.fs = (pos == 0);
            e.vb = (pos == VV * HT);
            raw.hs = (h >= HV + HF && h < HV + HF + HS) ? SA : ~SA;
            raw.vs = (v >= VV + VF && v < VV + VF + VS) ? SA : ~SA;
            raw.bn = e.br;
            pin_hist.push_back(raw);
            void'(pin_hist.pop_front());
        end
        e.hs = pin_hist[0].hs;
        e.vs = pin_hist[0].vs;
        e.bn = pin_hist[0].bn;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r);
        reset = r;
        model_step(r);
        @(posedge pix_clk);
        #1;
    endtask

    always @(posedge pix_clk) rst_seen <= reset;

    // Monitor: pops one expectation per cycle and gathers event statistics.
    initial begin
        obs_t a;
        obs_t e;
        forever begin
            @(negedge pix_clk);
            a.h  = hcount;
            a.v  = vcount;
            a.br = bright;
            a.fs = frame_start;
            a.vb = vblank_start;
            a.hs = hsync;
            a.vs = vsync;
            a.bn = blank_n;
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 1'b0, "empty queue", "pending entry");
            end else begin
                e = exp_q.pop_front();
                check($sformatf("cycle%0d_outputs", cyc), a === e, fmt(a), fmt(e));
            end
            if (frame_start && vblank_start) both_cnt++;
            if (rst_seen) begin
                since_rel = 0;
                fs_first  = -1;
                fs_last   = -1;
                fs_gap    = -1;
                fs_seen   = 0;
                vb_first  = -1;
                vb_seen   = 0;
                vs_frame2 = 0;
            end else begin
                since_rel++;
                if (frame_start) begin
                    fs_seen++;
                    if (fs_last >= 0) fs_gap = since_rel - fs_last;
                    else fs_first = since_rel;
                    fs_last = since_rel;
                end
                if (vblank_start) begin
                    vb_seen++;
                    if (vb_first < 0) vb_first = since_rel;
                end
                if (vsync == SA && since_rel > FRAME && since_rel <= 2 * FRAME) vs_frame2++;
            end
            cyc++;
        end
    end

    initial begin
        int target;
        int gap;

        // Reset held, then two undisturbed frames.
        repeat (5) drive(1'b1);
        repeat (2 * FRAME + 20) drive(1'b0);
        @(negedge pix_clk);
        #1;
        check_int("first_frame_start_cycle", fs_first, FRAME);
        check_int("frame_start_count", fs_seen, 2);
        check_int("frame_period", fs_gap, FRAME);
        check_int("first_vblank_cycle", vb_first, VV * HT);
        check_int("vblank_count", vb_seen, 2);
        check_int("vsync_active_cycles", vs_frame2, VS * HT);

        // Single-cycle reset while both syncs are active.
        target = (VV + VF) * HT + HV + HF + 2;
        while (pos != target) drive(1'b0);
        drive(1'b1);
        repeat (40) drive(1'b0);

        // Random reset pulses at arbitrary raster positions.
        repeat (6) begin
            gap = int'($urandom_range(1400, 50));
            repeat (gap) drive(1'b0);
            repeat (int'($urandom_range(3, 1))) drive(1'b1);
        end
        repeat (50) drive(1'b0);

        @(negedge pix_clk);
        #1;
        check_int("frame_start_vblank_overlap", both_cnt, 0);
        check_int("scoreboard_leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock. Drives `hcount`, `vcount` and `bright` into the bitgen stages (background, sprite) and drives `hsync`/`vsync` to the DAC pins. It also emits per-frame event pulses for game-state logic such as scroll and sprite updates. An optional sync-delay pipeline keeps pin-side sync/blank aligned with bitgen RGB, which lags by the ROM read latency.

## Interface

Parameters:
- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync pulse width, pixels
- `H_BACK`, 48: horizontal back porch, pixels
- `V_VISIBLE`, 480: active lines
- `V_FRONT`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BACK`, 33: vertical back porch, lines
- `SYNC_ACTIVE`, 1'b0: asserted level of hsync/vsync
- `SYNC_DELAY`, 2: pin-side pipeline depth, 1..7; only used with `VGA_SYNC_DELAY_EN`

Ports:
- `pix_clk`, in, 1: pixel clock, the only clock
- `reset`, in, 1: synchronous, active-high
- `hcount`, out, 10: horizontal position 0..799
- `vcount`, out, 10: vertical position 0..524
- `bright`, out, 1: high when hcount < 640 and vcount < 480; aligned with the counters; feeds bitgens
- `frame_start`, out, 1: one-cycle pulse when (hcount, vcount) = (0, 0)
- `vblank_start`, out, 1: one-cycle pulse when (hcount, vcount) = (0, 480)
- `hsync`, out, 1: pin hsync
- `vsync`, out, 1: pin vsync
- `blank_n`, out, 1: pin-side bright, used to gate DAC RGB

## Operation

- Totals: H_TOTAL = 800, V_TOTAL = 525. Counters are registers.
- hcount increments every cycle.
  - At H_TOTAL-1 it wraps to 0 and vcount increments.
  - When vcount is at V_TOTAL-1 on the same cycle, vcount wraps to 0.
- All decoded outputs are registered. They are computed from the next counter value, so in any cycle they describe the current (hcount, vcount) with zero skew.
- Decode windows:
  - hsync is asserted for hcount 656..751 inclusive (H_VISIBLE+H_FRONT through +H_SYNC-1).
  - vsync is asserted for the whole of lines 490..491, including the porch pixels of those lines.
  - bright is active for hcount 0..639 and vcount 0..479.
- Event pulses:
  - frame_start and vblank_start are high for exactly one cycle per frame.
  - They never assert together.
- Parameter widths: counters are 10 bits. Any parameter set with H_TOTAL or V_TOTAL > 1024 is illegal.
- No handshake. Downstream stages sample the outputs every cycle.

## Timing

- Reset values while `reset` is high:
  - hcount = 0, vcount = 0
  - bright = 0, frame_start = 0, vblank_start = 0
  - hsync = vsync = ~SYNC_ACTIVE
  - blank_n = 0
  - delay pipeline fully cleared to the inactive values above
- First cycle after reset deasserts: hcount = 1, vcount = 0. The first frame's pixel (0,0) is therefore dark and frame_start does not pulse. The first frame_start is at cycle 420000 after release.
- Reset mid-frame: returns to the reset values on the next edge, with no partial sync pulse extension. The sync level goes inactive the same edge.
- Latency to bitgen ports (hcount, vcount, bright): 0 cycles relative to each other.
- Latency to pin ports (hsync, vsync, blank_n): see Configuration.
- Frame period: exactly 420000 pix_clk cycles.

## Configuration

Macro: `VGA_SYNC_DELAY_EN`.
- Defined:
  - hsync, vsync and blank_n pass through a SYNC_DELAY-stage register pipeline. They lag hcount/bright by exactly SYNC_DELAY cycles, matching the bitgen ROM read plus RGB register.
  - Reset clears every stage to inactive.
- Undefined:
  - No pipeline is built and SYNC_DELAY is ignored.
  - hsync, vsync and blank_n equal the undelayed decodes; blank_n equals bright.

## Test plan

1. Reset held for 5 cycles, then released: all outputs match the reset values listed above during reset. hcount reads 1 and vcount 0 on the first post-release cycle.
2. Run one line, macro undefined: hsync goes low at hcount 656 and high at 752. bright falls at hcount 640. At hcount 799 to 0, vcount increments by 1.
3. Run one full frame: vsync is low only for vcount 490–491, 1600 cycles total. vblank_start pulses once at (0,480). frame_start pulses once at (0,0) after (799,524). Period measures 420000.
4. Macro defined with SYNC_DELAY=2: hsync falls 2 cycles after hcount reaches 656. blank_n falls 2 cycles after bright. blank_n rises 2 cycles after frame_start.
5. Assert reset for 1 cycle at (hcount=700, vcount=490), during both syncs active: next cycle shows hsync = vsync = 1 and counters at 0. With the macro defined, no delayed sync-low emerges from the pipeline afterward.
6. Two consecutive frames: exactly two frame_start pulses, 420000 cycles apart, and no cycle where frame_start and vblank_start are both high.
